// File: rtl/rate_controller_if.sv
// Control/status bundle between the front-panel logic and the rate controller.
interface rate_controller_if;
  logic [1:0] speed;
  logic       start;
  logic       stop;
  logic       step;
  logic       tick;
  logic       running;
  logic [1:0] speed_active;

  // Drives the requests and observes the status.
  modport master (
    output speed, start, stop, step,
    input  tick, running, speed_active
  );

  // The rate controller itself.
  modport slave (
    input  speed, start, stop, step,
    output tick, running, speed_active
  );
endinterface

// File: rtl/rate_controller.sv
// Tick generator for a display counter: full rate or 4/2/1 Hz derived from
// CLK_HZ, with start/stop/single-step control and a glitch-free registered tick.
module rate_controller #(
  parameter int CLK_HZ = 50000000
) (
  input  logic              clock,
  input  logic              clear_b,
  rate_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

  // Reload values; the count runs R..0, so a period is R+1 cycles.
  localparam logic [25:0] R_QTR  = 26'(CLK_HZ / 4 - 1);
  localparam logic [25:0] R_HALF = 26'(CLK_HZ / 2 - 1);
  localparam logic [25:0] R_FULL = 26'(CLK_HZ - 1);

  function automatic logic [25:0] reload(input logic [1:0] s);
    case (s)
      2'b00:   reload = '0;
      2'b01:   reload = R_QTR;
      2'b10:   reload = R_HALF;
      default: reload = R_FULL;
    endcase
  endfunction

  state_t      state, state_nxt;
  logic [25:0] count, count_nxt;
  logic        tick_q, tick_nxt;
  logic        running_q;
  logic [1:0]  spd_q, spd_nxt;

  // State and datapath registers; clear_b acts without waiting for a clock.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      state     <= IDLE;
      count     <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      spd_q     <= 2'b00;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      tick_q    <= tick_nxt;
      running_q <= (state_nxt == RUN);
      spd_q     <= spd_nxt;
    end
  end

  // Next-state and next-output decode; stop outranks start, start outranks step.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tick_nxt  = 1'b0;
    spd_nxt   = spd_q;
    case (state)
      IDLE: begin
        count_nxt = reload(spd_q);
        if (!bus.stop && bus.start) begin
          state_nxt = RUN;
          spd_nxt   = bus.speed;
          count_nxt = reload(bus.speed);
        end else if (!bus.stop && bus.step) begin
          // Tick is registered, so it is high exactly while STEP is held.
          state_nxt = STEP;
          tick_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          count_nxt = reload(spd_q);
        end else if (count == '0) begin
          // Period boundary: emit tick and pick up any new speed here only.
          tick_nxt  = 1'b1;
          spd_nxt   = bus.speed;
          count_nxt = reload(bus.speed);
        end else begin
          count_nxt = count - 26'd1;
        end
      end
      STEP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.tick         = tick_q;
  assign bus.running      = running_q;
  assign bus.speed_active = spd_q;

endmodule

// File: tb/tb_rate_controller.sv
// Directed bench for rate_controller at CLK_HZ=8 (reloads 0/1/3/7).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_rate_controller;

  logic clock = 1'b0;
  logic clear_b = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ticks;

  rate_controller_if bus ();

  rate_controller #(.CLK_HZ(8)) dut (
    .clock   (clock),
    .clear_b (clear_b),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    bus.speed = 2'b00;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.step  = 1'b0;

    // Reset state, before any clock edge.
    #2;
    chk("rst_tick", bus.tick, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_speed_active", bus.speed_active, 0);
    cyc(2);
    clear_b = 1'b1;
    cyc(1);
    chk("post_rst_tick", bus.tick, 0);
    chk("post_rst_running", bus.running, 0);

    // 4 Hz from start: tick after edges 2, 4, 6.
    bus.speed = 2'b01;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk("run01_running", bus.running, 1);
    chk("run01_tick_e0", bus.tick, 0);
    chk("run01_speed_active", bus.speed_active, 1);
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      chk($sformatf("run01_tick_e%0d", i), bus.tick, (i % 2 == 0) ? 1 : 0);
    end

    // Switch to 1 Hz: takes effect at the reload two edges later (edge 8).
    bus.speed = 2'b11;
    cyc(2);
    chk("to11_tick", bus.tick, 1);
    chk("to11_speed_active", bus.speed_active, 3);
    // Mid-period change to 4 Hz: the 8-cycle period finishes first.
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (k == 2) bus.speed = 2'b01;
      if (k <= 8) begin
        chk($sformatf("p11_tick_k%0d", k), bus.tick, (k == 8) ? 1 : 0);
        chk($sformatf("p11_sa_k%0d", k), bus.speed_active, (k == 8) ? 1 : 3);
      end else begin
        chk($sformatf("p01_tick_k%0d", k), bus.tick, (k % 2 == 0) ? 1 : 0);
      end
    end

    // 2 Hz, then stop on the edge where the count is zero.
    bus.speed = 2'b10;
    cyc(2);
    chk("to10_tick", bus.tick, 1);
    chk("to10_speed_active", bus.speed_active, 2);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      chk($sformatf("p10_tick_k%0d", k), bus.tick, 0);
    end
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk("stop_at_zero_tick", bus.tick, 0);
    chk("stop_at_zero_running", bus.running, 0);
    chk("stop_keeps_speed_active", bus.speed_active, 2);
    cyc(1);
    chk("idle_tick", bus.tick, 0);
    chk("idle_running", bus.running, 0);

    // Single step from IDLE.
    bus.step = 1'b1;
    cyc(1);
    bus.step = 1'b0;
    chk("step_tick", bus.tick, 1);
    chk("step_running", bus.running, 0);
    cyc(1);
    chk("step_done_tick", bus.tick, 0);
    cyc(1);
    chk("step_idle_tick", bus.tick, 0);

    // start+stop together in IDLE: stay idle.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("startstop_running", bus.running, 0);
    chk("startstop_tick", bus.tick, 0);
    cyc(1);
    chk("startstop_tick2", bus.tick, 0);

    // Full rate: tick high every cycle from edge 1 until stop.
    bus.speed = 2'b00;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk("full_running", bus.running, 1);
    chk("full_tick_e0", bus.tick, 0);
    chk("full_speed_active", bus.speed_active, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      chk($sformatf("full_tick_e%0d", i), bus.tick, 1);
    end
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk("full_stop_tick", bus.tick, 0);
    chk("full_stop_running", bus.running, 0);

    // Asynchronous clear mid-period at 1 Hz.
    bus.speed = 2'b11;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(3);
    chk("pre_clr_running", bus.running, 1);
    chk("pre_clr_speed_active", bus.speed_active, 3);
    #2;
    clear_b = 1'b0;
    #1;
    chk("async_clr_tick", bus.tick, 0);
    chk("async_clr_running", bus.running, 0);
    chk("async_clr_speed_active", bus.speed_active, 0);
    cyc(1);
    clear_b = 1'b1;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus.tick) ticks++;
    end
    chk("post_clr_ticks", ticks, 0);
    chk("post_clr_running", bus.running, 0);

    // step held through STEP: the second one is ignored.
    bus.step = 1'b1;
    cyc(1);
    chk("hold_step_tick1", bus.tick, 1);
    cyc(1);
    bus.step = 1'b0;
    chk("hold_step_tick2", bus.tick, 0);
    chk("hold_step_running", bus.running, 0);
    cyc(1);
    chk("hold_step_tick3", bus.tick, 0);

    // step pulses during RUN at 4 Hz are ignored: 16 ticks in 32 cycles.
    bus.speed = 2'b01;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    ticks = 0;
    for (int i = 1; i <= 32; i++) begin
      bus.step = (i == 3 || i == 8 || i == 13) ? 1'b1 : 1'b0;
      cyc(1);
      if (bus.tick) ticks++;
    end
    bus.step = 1'b0;
    chk("run_step_ticks", ticks, 16);
    chk("run_step_running", bus.running, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
